// File: rtl/univ_shift_seq_if.sv
// Command/response port and register-drive bundle for the shift-register sequencer.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side, rsp_valid/rsp_ready on the result side.
interface univ_shift_seq_if #(
   parameter int DW    = 4,
   parameter int AMT_W = 3
);
   // command side
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [AMT_W-1:0] cmd_amt;
   logic [DW-1:0]    cmd_data;

   // result side
   logic             rsp_valid;
   logic             rsp_ready;
   logic [DW-1:0]    rsp_q;
   logic             busy;

   // external universal shift register
   logic             usr_sync_rst;
   logic [1:0]       usr_ctrl;
   logic [DW-1:0]    usr_data;
   logic             usr_data_l;
   logic             usr_data_h;
   logic [DW-1:0]    usr_q;

   // sequencer side
   modport slave (
      input  cmd_valid, cmd_op, cmd_amt, cmd_data, rsp_ready, usr_q,
      output cmd_ready, rsp_valid, rsp_q, busy,
             usr_sync_rst, usr_ctrl, usr_data, usr_data_l, usr_data_h
   );

   // requester plus shift-register side
   modport master (
      output cmd_valid, cmd_op, cmd_amt, cmd_data, rsp_ready, usr_q,
      input  cmd_ready, rsp_valid, rsp_q, busy,
             usr_sync_rst, usr_ctrl, usr_data, usr_data_l, usr_data_h
   );
endinterface

// File: rtl/univ_shift_seq.sv
// Sequences load/shift/rotate/clear commands onto an external universal shift register.
// Latency: LOAD/CLEAR result 2 cycles after accept, shift/rotate by n 1+n cycles, NOP or zero count 1 cycle.
// Backpressure: cmd_ready only when idle; result held in DONE until rsp_ready, then one idle cycle.
module univ_shift_seq #(
   parameter int DW    = 4,
   parameter int AMT_W = 3
) (
   input  logic            clk,
   input  logic            sync_rst,
   univ_shift_seq_if.slave bus
);

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_SHL   = 3'd1;
   localparam logic [2:0] OP_SHR   = 3'd2;
   localparam logic [2:0] OP_ASR   = 3'd3;
   localparam logic [2:0] OP_ROL   = 3'd4;
   localparam logic [2:0] OP_ROR   = 3'd5;
   localparam logic [2:0] OP_CLEAR = 3'd6;
   localparam logic [2:0] OP_NOP   = 3'd7;

   // register ctrl encodings: shift toward bit 0 fills from data_h, toward MSB fills from data_l
   localparam logic [1:0] CTRL_LOAD   = 2'b00;
   localparam logic [1:0] CTRL_TO_LSB = 2'b01;
   localparam logic [1:0] CTRL_TO_MSB = 2'b10;
   localparam logic [1:0] CTRL_HOLD   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] remaining;
   logic [DW-1:0]    data_q;
   logic             accept;
   logic             skip_exec;
   logic             last_step;
   logic             clear_pulse;

   function automatic logic is_shift_op(input logic [2:0] op);
      return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR) ||
             (op == OP_ROL) || (op == OP_ROR);
   endfunction

   assign accept    = (state == IDLE) && !sync_rst && bus.cmd_valid;
   // zero-count shifts and NOP never touch the register, so they go straight to DONE
   assign skip_exec = (bus.cmd_op == OP_NOP) ||
                      (is_shift_op(bus.cmd_op) && (bus.cmd_amt == '0));
   // LOAD/CLEAR take a single step; shifts stop after the step that sees remaining == 1
   assign last_step = !is_shift_op(op_q) || (remaining == AMT_W'(1));

   // state register; reset from any state aborts the command in flight
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = skip_exec ? DONE : EXEC;
            end
         end
         EXEC: begin
            if (last_step) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // command latch and step counter
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         op_q      <= OP_NOP;
         remaining <= '0;
         data_q    <= '0;
      end else if (accept) begin
         op_q      <= bus.cmd_op;
         remaining <= bus.cmd_amt;
         data_q    <= bus.cmd_data;
      end else if ((state == EXEC) && (remaining != '0)) begin
         remaining <= remaining - AMT_W'(1);
      end
   end

   // output decode: register drive in EXEC, hold everywhere else
   always_comb begin
      bus.cmd_ready  = 1'b0;
      bus.rsp_valid  = 1'b0;
      bus.rsp_q      = '0;
      bus.busy       = (state != IDLE);
      bus.usr_ctrl   = CTRL_HOLD;
      bus.usr_data   = '0;
      bus.usr_data_l = 1'b0;
      bus.usr_data_h = 1'b0;
      clear_pulse    = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = !sync_rst;
         end
         EXEC: begin
            case (op_q)
               OP_LOAD: begin
                  bus.usr_ctrl = CTRL_LOAD;
                  bus.usr_data = data_q;
               end
               OP_CLEAR: begin
                  clear_pulse = 1'b1;
               end
               OP_SHL: begin
                  bus.usr_ctrl   = CTRL_TO_MSB;
                  bus.usr_data_l = 1'b0;
               end
               OP_SHR: begin
                  bus.usr_ctrl   = CTRL_TO_LSB;
                  bus.usr_data_h = 1'b0;
               end
               OP_ASR: begin
                  bus.usr_ctrl   = CTRL_TO_LSB;
                  bus.usr_data_h = bus.usr_q[DW-1];
               end
               OP_ROL: begin
                  bus.usr_ctrl   = CTRL_TO_MSB;
                  bus.usr_data_l = bus.usr_q[DW-1];
               end
               OP_ROR: begin
                  bus.usr_ctrl   = CTRL_TO_LSB;
                  bus.usr_data_h = bus.usr_q[0];
               end
               default: begin
                  bus.usr_ctrl = CTRL_HOLD;
               end
            endcase
         end
         DONE: begin
            // register is held here, so usr_q is the stable result
            bus.rsp_valid = !sync_rst;
            bus.rsp_q     = bus.usr_q;
         end
         default: begin
            bus.usr_ctrl = CTRL_HOLD;
         end
      endcase
      bus.usr_sync_rst = sync_rst | clear_pulse;
   end

   // a command can only be offered while the sequencer is idle
   a_ready_not_busy : assert property (@(posedge clk) bus.cmd_ready |-> !bus.busy);

endmodule
